// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues ROM reads, catches the 1-cycle-latency data
// in an output entry plus a skid entry, and hands words to decode in order.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          WORD_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imrom_addr,
    input  logic [31:0] imrom_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    logic [31:0] pc_q, pc_d;
    logic        reqValid_q, reqValid_d;
    logic [31:0] reqPc_q, reqPc_d;
    logic        outValid_q, outValid_d;
    logic [31:0] outInstr_q, outInstr_d;
    logic [31:0] outPc_q, outPc_d;
    logic        skidValid_q, skidValid_d;
    logic [31:0] skidInstr_q, skidInstr_d;
    logic [31:0] skidPc_q, skidPc_d;

    logic        fire;
    logic        issue;
    logic [1:0]  occupancy;
    logic [31:0] redirectAligned;

    assign imrom_addr      = WORD_ADDR ? {2'b00, pc_q[31:2]} : pc_q;
    assign id_valid        = outValid_q;
    assign id_instr        = outInstr_q;
    assign id_pc           = outPc_q;
    assign redirectAligned = redirect_pc & 32'hFFFF_FFFC;

    // Occupancy counts the slot a firing entry is about to free, so a full
    // stream keeps exactly one word held and one read in flight.
    always_comb begin
        fire      = outValid_q & id_ready;
        occupancy = {1'b0, outValid_q} + {1'b0, skidValid_q} + {1'b0, reqValid_q}
                    - {1'b0, fire};
        issue     = !rst && !redirect_valid && !halt && (occupancy < 2'd2);
    end

    always_comb begin
        pc_d        = pc_q;
        reqValid_d  = reqValid_q;
        reqPc_d     = reqPc_q;
        outValid_d  = outValid_q;
        outInstr_d  = outInstr_q;
        outPc_d     = outPc_q;
        skidValid_d = skidValid_q;
        skidInstr_d = skidInstr_q;
        skidPc_d    = skidPc_q;

        if (rst) begin
            pc_d        = RESET_PC;
            reqValid_d  = 1'b0;
            reqPc_d     = 32'h0;
            outValid_d  = 1'b0;
            outInstr_d  = 32'h0;
            outPc_d     = 32'h0;
            skidValid_d = 1'b0;
            skidInstr_d = 32'h0;
            skidPc_d    = 32'h0;
        end else if (redirect_valid) begin
            pc_d        = redirectAligned;
            reqValid_d  = 1'b0;
            outValid_d  = 1'b0;
            skidValid_d = 1'b0;
        end else begin
            reqValid_d = issue;
            if (issue) begin
                reqPc_d = pc_q;
                pc_d    = pc_q + 32'd4;
            end

            // The skid always drains into the output first to preserve order.
            if (fire && skidValid_q) begin
                outValid_d  = 1'b1;
                outInstr_d  = skidInstr_q;
                outPc_d     = skidPc_q;
                skidValid_d = reqValid_q;
                if (reqValid_q) begin
                    skidInstr_d = imrom_out;
                    skidPc_d    = reqPc_q;
                end
            end else if (!outValid_q || fire) begin
                outValid_d = reqValid_q;
                if (reqValid_q) begin
                    outInstr_d = imrom_out;
                    outPc_d    = reqPc_q;
                end
            end else if (reqValid_q) begin
                skidValid_d = 1'b1;
                skidInstr_d = imrom_out;
                skidPc_d    = reqPc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q        <= pc_d;
        reqValid_q  <= reqValid_d;
        reqPc_q     <= reqPc_d;
        outValid_q  <= outValid_d;
        outInstr_q  <= outInstr_d;
        outPc_q     <= outPc_d;
        skidValid_q <= skidValid_d;
        skidInstr_q <= skidInstr_d;
        skidPc_q    <= skidPc_d;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected PCs popped on
// every decode transfer, plus timing checks around reset, stall, halt, redirect.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        idReady;
    logic        halt;
    logic        redirValid;
    logic [31:0] redirPc;

    logic [31:0] imromAddr, romData;
    logic        idValid;
    logic [31:0] idInstr, idPc;

    logic [31:0] imromAddrW, romDataW;
    logic        idValidW;
    logic [31:0] idInstrW, idPcW;

    logic [31:0] expQ[$];
    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] stallPc, haltPc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .WORD_ADDR(1'b1)) dut (
        .clk(clk), .rst(rst), .imrom_addr(imromAddr), .imrom_out(romData),
        .redirect_valid(redirValid), .redirect_pc(redirPc), .halt(halt),
        .id_valid(idValid), .id_ready(idReady), .id_instr(idInstr), .id_pc(idPc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .WORD_ADDR(1'b1)) dutW (
        .clk(clk), .rst(rst), .imrom_addr(imromAddrW), .imrom_out(romDataW),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .halt(1'b0),
        .id_valid(idValidW), .id_ready(1'b1), .id_instr(idInstrW), .id_pc(idPcW)
    );

    // ROM models with one cycle of read latency; word i holds A000_0000 + i.
    always @(posedge clk) begin
        romData  <= 32'hA000_0000 + imromAddr;
        romDataW <= 32'hA000_0000 + imromAddrW;
    end

    function automatic logic [31:0] romWord(input logic [31:0] pc);
        return 32'hA000_0000 + (pc >> 2);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pushRange(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) expQ.push_back(base + 32'(i * 4));
    endtask

    // Drive one cycle of inputs, score the transfer that the coming edge
    // performs, then advance to the next falling edge.
    task automatic applyStimulus(input logic readyV, input logic haltV,
                                 input logic redirV, input logic [31:0] rpcV,
                                 input logic rstV);
        logic [31:0] expPc;
        idReady    = readyV;
        halt       = haltV;
        redirValid = redirV;
        redirPc    = rpcV;
        rst        = rstV;
        if (idValid === 1'b1 && readyV && !rstV) begin
            if (expQ.size() == 0) begin
                checkOutput("sbEmpty", 32'(expQ.size()), 32'd1);
            end else begin
                expPc = expQ.pop_front();
                checkOutput("fireId_pc", idPc, expPc);
                checkOutput("fireId_instr", idInstr, romWord(expPc));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; idReady = 1'b0; halt = 1'b0; redirValid = 1'b0; redirPc = 32'h0;

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rstValid", 32'(idValid), 32'd0);
        checkOutput("rstPc", idPc, 32'h0);
        checkOutput("rstInstr", idInstr, 32'h0);
        checkOutput("rstAddr", imromAddr, 32'h0);
        checkOutput("wrapAddr0", imromAddrW, 32'h3FFF_FFFE);

        // Streaming from reset, with the wrapping instance alongside.
        pushRange(32'h0, 64);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            if (k == 1) begin
                checkOutput("firstValidEarly", 32'(idValid), 32'd0);
                checkOutput("wrapAddr1", imromAddrW, 32'h3FFF_FFFF);
            end else begin
                checkOutput("streamValid", 32'(idValid), 32'd1);
            end
            if (k == 2) begin
                checkOutput("firstPc", idPc, 32'h0);
                checkOutput("wrapAddr2", imromAddrW, 32'h0);
                checkOutput("wrapPc0", idPcW, 32'hFFFF_FFF8);
            end
            if (k == 3) checkOutput("wrapPc1", idPcW, 32'hFFFF_FFFC);
            if (k == 4) begin
                checkOutput("wrapPc2", idPcW, 32'h0000_0000);
                checkOutput("wrapInstr2", idInstrW, romWord(32'h0));
                checkOutput("wrapValid", 32'(idValidW), 32'd1);
            end
        end

        // Backpressure: outputs held, fetch PC frozen two words ahead.
        stallPc = expQ[0];
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("stallValid", 32'(idValid), 32'd1);
            checkOutput("stallPc", idPc, stallPc);
            checkOutput("stallInstr", idInstr, romWord(stallPc));
            checkOutput("stallAddr", imromAddr, (stallPc + 32'd8) >> 2);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("resumeValid", 32'(idValid), 32'd1);
        end

        // Halt: the in-flight word still arrives, then the stage runs dry.
        haltPc = expQ[0];
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            checkOutput("haltValid", 32'(idValid), 32'(i == 0));
            checkOutput("haltAddr", imromAddr, (haltPc + 32'd8) >> 2);
            if (i == 0) checkOutput("haltPc", idPc, haltPc + 32'd4);
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("haltResumeValid", 32'(idValid), 32'd1);

        // Redirect with output and skid both full.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        expQ.delete();
        pushRange(32'h0000_0100, 32);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        checkOutput("redirFlushValid", 32'(idValid), 32'd0);
        checkOutput("redirAddr", imromAddr, 32'h0000_0040);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("redirGapValid", 32'(idValid), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("redirValid", 32'(idValid), 32'd1);
        checkOutput("redirPc", idPc, 32'h0000_0100);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset mid-stream, then restart from RESET_PC.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("midRstValid", 32'(idValid), 32'd0);
        checkOutput("midRstPc", idPc, 32'h0);
        checkOutput("midRstInstr", idInstr, 32'h0);
        checkOutput("midRstAddr", imromAddr, 32'h0);
        expQ.delete();
        pushRange(32'h0, 16);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("restartEarly", 32'(idValid), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("restartValid", 32'(idValid), 32'd1);
        checkOutput("restartPc", idPc, 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning byte address of the first fetch after reset.
REQ-002 SHALL have parameter WORD_ADDR, default 1, meaning imrom_addr = pc[31:2] zero-extended when 1 and pc when 0.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 imrom_addr  output  32  instruction ROM read address; the ROM samples it on the rising edge.
REQ-007 imrom_out  input  32  ROM data; valid in the cycle after its address was presented (1-cycle latency).
REQ-008 redirect_valid  input  1  branch/jump taken; flush and restart at redirect_pc.
REQ-009 redirect_pc  input  32  new byte PC; bits [1:0] are ignored and forced to 0.
REQ-010 halt  input  1  while high, no new fetch is issued; held instructions remain deliverable.
REQ-011 id_valid  output  1  instruction available to decode.
REQ-012 id_ready  input  1  decode accepts; transfer ("fire") = id_valid & id_ready.
REQ-013 id_instr  output  32  instruction word.
REQ-014 id_pc  output  32  byte PC of id_instr.

Function
REQ-015 SHALL hold the following state:
- pc_q: next fetch byte PC.
- req_valid/req_pc: one ROM read in flight.
- out entry: id_valid/id_instr/id_pc.
- skid entry: skid_valid/skid_instr/skid_pc.
REQ-016 SHALL drive imrom_addr from pc_q per WORD_ADDR every cycle; reads without issue are harmless and their data is ignored.
REQ-017 SHALL issue a fetch in a cycle iff all hold: !rst, !redirect_valid, !halt, and (id_valid + skid_valid + req_valid - fire) < 2.
REQ-018 On issue SHALL set req_valid=1, req_pc=pc_q, pc_q=pc_q+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); otherwise req_valid=0 and pc_q holds.
REQ-019 When req_valid=1, SHALL capture imrom_out with req_pc in that same cycle:
- into the out entry if it is empty or firing and the skid is empty;
- else into the skid.
REQ-020 On fire with skid_valid=1, SHALL move the skid to the out entry (FIFO order); the returning ROM word goes to the skid.
REQ-021 SHALL deliver instructions to decode in strictly increasing fetch order with no loss or duplication; total held + in flight never exceeds 2.
REQ-022 SHALL keep id_valid, id_instr and id_pc stable while id_valid & !id_ready, except on rst or redirect_valid.
REQ-023 redirect_valid in cycle N SHALL:
- at edge N clear req_valid, id_valid and skid_valid;
- set pc_q = {redirect_pc[31:2],2'b00};
- discard the ROM data returning in N+1;
- present the redirect address in N+1;
- give the earliest id_valid for it in N+2.
REQ-024 redirect_valid SHALL take priority over fire, ROM return and issue in the same cycle; a fire coinciding with redirect still counts as accepted by decode.
REQ-025 halt SHALL only block issue; an in-flight read still lands, and redirect during halt updates pc_q and flushes.
REQ-026 With id_ready held high and no halt/redirect, SHALL sustain one instruction per cycle.

Reset
REQ-027 On rst=1 at an edge, SHALL set pc_q=RESET_PC, req_valid=0, id_valid=0, skid_valid=0, id_instr=0, id_pc=0, skid_instr=0, skid_pc=0, overriding redirect and fire.
REQ-028 Reset mid-operation SHALL discard all in-flight and held instructions; the first fetch after release is RESET_PC.
REQ-029 With rst released before edge E1, id_valid SHALL first rise after edge E2, with id_pc=RESET_PC.

Verification
REQ-030 Streaming: ROM[i]=32'hA000_0000+i, id_ready=1 -> id_pc 0,4,8,... each cycle; id_instr matches; first valid 2 edges after reset.
REQ-031 Backpressure: id_ready low 5 cycles mid-stream, then high -> outputs held stable; no more than 2 fetches issued past the stall point; order preserved, no gaps.
REQ-032 Redirect: redirect_valid one cycle with redirect_pc=32'h0000_0103 while out and skid are full -> both flushed; next id_pc=32'h0000_0100, 2 cycles later; stale words never seen.
REQ-033 Wrap: RESET_PC=32'hFFFF_FFF8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; imrom_addr 3FFF_FFFE, 3FFF_FFFF, 0.
REQ-034 Halt and reset: halt=1 for 4 cycles with id_ready=1 -> in-flight word delivered, then id_valid=0 and pc_q frozen; rst mid-stream -> all outputs zero next cycle; restart at RESET_PC.
